// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with packet locking for VC/switch allocation.
// Each requester gets up to `weight` packets per turn; multi-flit packets keep the grant until the tail.
module wrr_lock_arbiter #(
   parameter int ARBITER_WIDTH = 8,
   parameter int WEIGHT_W      = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [ARBITER_WIDTH-1:0]          request,
   input  logic [ARBITER_WIDTH-1:0]          hold,
   input  logic [ARBITER_WIDTH*WEIGHT_W-1:0] weight,
   input  logic                              grant_accept,
   output logic [ARBITER_WIDTH-1:0]          grant,
   output logic                              any_grant,
   output logic                              locked
);

   localparam int N     = ARBITER_WIDTH;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   // Handshake: a grant is offered combinationally every cycle; it is consumed
   // only when any_grant and grant_accept are both high in the same cycle, and
   // only a consume may change priority, credit or lock state.
   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t           state;
   logic [N-1:0]          priority_reg;
   logic [WEIGHT_W-1:0]   credit;

   logic [IDX_W-1:0]      pri_idx;
   logic [IDX_W-1:0]      g_idx;
   logic [N-1:0]          search_grant;
   logic                  found;
   int                    idx;
   logic [WEIGHT_W-1:0]   w_sel;
   logic [WEIGHT_W-1:0]   w_eff;
   logic [WEIGHT_W-1:0]   ce;
   logic                  same_owner;
   logic                  h;
   logic                  consume;
   logic [N-1:0]          rotated;

   always_comb begin
      pri_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (priority_reg[i]) pri_idx = IDX_W'(i);
      end
   end

   // Circular search starting at the priority position, inclusive.
   always_comb begin
      search_grant = '0;
      found        = 1'b0;
      idx          = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(pri_idx) + k;
         if (idx >= N) idx = idx - N;
         if (!found && request[idx]) begin
            search_grant[idx] = 1'b1;
            found             = 1'b1;
         end
      end
   end

   always_comb begin
      if (reset)
         grant = '0;
      else if (state == LOCKED)
         grant = priority_reg & request;
      else
         grant = search_grant;
   end

   assign any_grant = |grant;
   assign locked    = (state == LOCKED);
   assign consume   = any_grant & grant_accept;

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) g_idx = IDX_W'(i);
      end
   end

   assign w_sel      = weight[int'(g_idx)*WEIGHT_W +: WEIGHT_W];
   assign w_eff      = (w_sel == '0) ? WEIGHT_W'(1) : w_sel;
   assign same_owner = (grant == priority_reg) && (credit != '0);
   assign ce         = same_owner ? credit : w_eff;
   assign h          = |(grant & hold);
   assign rotated    = {grant[N-2:0], grant[N-1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= UNLOCKED;
         priority_reg <= N'(1);
         credit       <= '0;
      end else if (consume) begin
         if (h) begin
            // Non-tail flit: lock on the owner, credit is charged only at the tail.
            state        <= LOCKED;
            priority_reg <= grant;
            credit       <= ce;
         end else begin
            state <= UNLOCKED;
            if (ce > WEIGHT_W'(1)) begin
               priority_reg <= grant;
               credit       <= ce - WEIGHT_W'(1);
            end else begin
               priority_reg <= rotated;
               credit       <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Table-driven bench for wrr_lock_arbiter (N=4, WEIGHT_W=3) with an expected-value queue.
module tb_wrr_lock_arbiter;

   localparam int N  = 4;
   localparam int WW = 3;

   logic              clk;
   logic              reset;
   logic [N-1:0]      request;
   logic [N-1:0]      hold;
   logic [N*WW-1:0]   weight;
   logic              grant_accept;
   logic [N-1:0]      grant;
   logic              any_grant;
   logic              locked;

   wrr_lock_arbiter #(.ARBITER_WIDTH(N), .WEIGHT_W(WW)) dut (
      .clk          (clk),
      .reset        (reset),
      .request      (request),
      .hold         (hold),
      .weight       (weight),
      .grant_accept (grant_accept),
      .grant        (grant),
      .any_grant    (any_grant),
      .locked       (locked)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic            rst;
      logic [N-1:0]    req;
      logic [N-1:0]    hld;
      logic            acc;
      logic [N*WW-1:0] wgt;
      logic [N-1:0]    exp_grant;
      logic            exp_locked;
      string           name;
   } vec_t;

   vec_t        vecs[$];
   logic [5:0]  exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   localparam logic [N*WW-1:0] W_ONES = {3'd1, 3'd1, 3'd1, 3'd1};
   localparam logic [N*WW-1:0] W_T2   = {3'd1, 3'd0, 3'd1, 3'd3};
   localparam logic [N*WW-1:0] W_T6   = {3'd1, 3'd2, 3'd1, 3'd1};

   task automatic add(input string name, input logic rst, input logic [N-1:0] req,
                      input logic [N-1:0] hld, input logic acc, input logic [N*WW-1:0] wgt,
                      input logic [N-1:0] g, input logic lk);
      vec_t v;
      v.name = name; v.rst = rst; v.req = req; v.hld = hld; v.acc = acc;
      v.wgt = wgt; v.exp_grant = g; v.exp_locked = lk;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Driver: apply one vector after the edge, compare on the falling edge.
   task automatic step(input vec_t v);
      logic [5:0] e;
      @(posedge clk);
      #1;
      reset        = v.rst;
      request      = v.req;
      hold         = v.hld;
      grant_accept = v.acc;
      weight       = v.wgt;
      exp_q.push_back({|v.exp_grant, v.exp_locked, v.exp_grant});
      @(negedge clk);
      if (exp_q.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         e = exp_q.pop_front();
         chk({v.name, ".grant"},  grant,                 e[3:0]);
         chk({v.name, ".any"},    {3'b000, any_grant},   {3'b000, e[5]});
         chk({v.name, ".locked"}, {3'b000, locked},      {3'b000, e[4]});
      end
   endtask

   initial begin
      // T7: reset with all requesting
      add("t7_rst", 1, 4'b1111, 4'b0000, 1, W_ONES, 4'b0000, 0);
      // T1: plain round robin
      add("t1_g0", 0, 4'b1111, 4'b0000, 1, W_ONES, 4'b0001, 0);
      add("t1_g1", 0, 4'b1111, 4'b0000, 1, W_ONES, 4'b0010, 0);
      add("t1_g2", 0, 4'b1111, 4'b0000, 1, W_ONES, 4'b0100, 0);
      add("t1_g3", 0, 4'b1111, 4'b0000, 1, W_ONES, 4'b1000, 0);
      add("t1_g4", 0, 4'b1111, 4'b0000, 1, W_ONES, 4'b0001, 0);
      // T2: weight 3 on input 0, weight 0 on input 2
      add("t2_rst", 1, 4'b1111, 4'b0000, 1, W_T2, 4'b0000, 0);
      add("t2_a",   0, 4'b1111, 4'b0000, 1, W_T2, 4'b0001, 0);
      add("t2_b",   0, 4'b1111, 4'b0000, 1, W_T2, 4'b0001, 0);
      add("t2_c",   0, 4'b1111, 4'b0000, 1, W_T2, 4'b0001, 0);
      add("t2_d",   0, 4'b1111, 4'b0000, 1, W_T2, 4'b0010, 0);
      add("t2_e",   0, 4'b1111, 4'b0000, 1, W_T2, 4'b0100, 0);
      add("t2_f",   0, 4'b1111, 4'b0000, 1, W_T2, 4'b1000, 0);
      add("t2_g",   0, 4'b1111, 4'b0000, 1, W_T2, 4'b0001, 0);
      // owner drops request with credit left: next requester wins
      add("t2_drop", 0, 4'b1110, 4'b0000, 1, W_T2, 4'b0010, 0);
      add("t2_next", 0, 4'b1111, 4'b0000, 1, W_T2, 4'b0100, 0);
      // T3: multi-flit packet on input 1
      add("t3_rst", 1, 4'b0000, 4'b0000, 1, W_ONES, 4'b0000, 0);
      add("t3_c1",  0, 4'b0010, 4'b0010, 1, W_ONES, 4'b0010, 0);
      add("t3_c2",  0, 4'b0011, 4'b0010, 1, W_ONES, 4'b0010, 1);
      add("t3_c3",  0, 4'b0011, 4'b0010, 1, W_ONES, 4'b0010, 1);
      add("t3_tail",0, 4'b0011, 4'b0000, 1, W_ONES, 4'b0010, 1);
      add("t3_c5",  0, 4'b0011, 4'b0000, 1, W_ONES, 4'b0001, 0);
      // T4: owner drops request while locked
      add("t4_rst",  1, 4'b0000, 4'b0000, 1, W_ONES, 4'b0000, 0);
      add("t4_lock", 0, 4'b0010, 4'b0010, 1, W_ONES, 4'b0010, 0);
      add("t4_blk1", 0, 4'b0001, 4'b0000, 1, W_ONES, 4'b0000, 1);
      add("t4_blk2", 0, 4'b0001, 4'b0000, 1, W_ONES, 4'b0000, 1);
      add("t4_tail", 0, 4'b0011, 4'b0000, 1, W_ONES, 4'b0010, 1);
      add("t4_next", 0, 4'b0011, 4'b0000, 1, W_ONES, 4'b0001, 0);
      // T5: back-pressure freezes state
      add("t5_rst", 1, 4'b1111, 4'b0000, 1, W_ONES, 4'b0000, 0);
      for (int i = 0; i < 5; i++)
         add("t5_stall", 0, 4'b1111, 4'b0000, 0, W_ONES, 4'b0001, 0);
      add("t5_g0", 0, 4'b1111, 4'b0000, 1, W_ONES, 4'b0001, 0);
      add("t5_g1", 0, 4'b1111, 4'b0000, 1, W_ONES, 4'b0010, 0);
      add("t5_g2", 0, 4'b1111, 4'b0000, 1, W_ONES, 4'b0100, 0);
      add("t5_g3", 0, 4'b1111, 4'b0000, 1, W_ONES, 4'b1000, 0);
      add("t5_g4", 0, 4'b1111, 4'b0000, 1, W_ONES, 4'b0001, 0);
      // T6: reset mid-packet while locked with credit 2
      add("t6_rst0", 1, 4'b0000, 4'b0000, 1, W_T6, 4'b0000, 0);
      add("t6_lock", 0, 4'b0100, 4'b0100, 1, W_T6, 4'b0100, 0);
      add("t6_held", 0, 4'b0100, 4'b0100, 1, W_T6, 4'b0100, 1);
      add("t6_rst",  1, 4'b1111, 4'b0000, 1, W_T6, 4'b0000, 1);
      add("t6_g0",   0, 4'b1111, 4'b0000, 1, W_T6, 4'b0001, 0);
      add("t6_g1",   0, 4'b1111, 4'b0000, 1, W_T6, 4'b0010, 0);
      // hold of a non-granted requester is ignored
      add("hx_rst", 1, 4'b0000, 4'b0000, 1, W_ONES, 4'b0000, 0);
      add("hx_a",   0, 4'b0001, 4'b1110, 1, W_ONES, 4'b0001, 0);
      add("hx_b",   0, 4'b0001, 4'b1110, 1, W_ONES, 4'b0001, 0);

      reset        = 1'b1;
      request      = '0;
      hold         = '0;
      grant_accept = 1'b0;
      weight       = W_ONES;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) step(vecs[i]);

      if (exp_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
